oob_ctrl: RTL and testbench

//  Upstream supervisor of the SATA OOB unit. Decides when to issue oob_start, grants device-initiated

---
 rtl/oob_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_oob_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oob_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : oob_ctrl
//  Purpose  : Upstream supervisor of the SATA OOB unit. Issues oob_start,
//             grants device-initiated COMINIT, retries failed OOB attempts
//             after a back-off, filters link loss and runs the TX PCS
//             recalibration handshake towards the GTX.
//  Revision : 1.0  initial release
// ============================================================================
module oob_ctrl #(
    parameter int RETRY_WAIT     = 20000,
    parameter int MAX_RETRIES    = 8,
    parameter int PCS_RST_CYCLES = 8,
    parameter int PCS_RST_TMO    = 4096,
    parameter int LINKDOWN_FILT  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    output logic       oob_start_o,
    input  logic       oob_busy_i,
    input  logic       oob_done_i,
    input  logic       oob_error_i,
    input  logic       oob_silence_i,
    input  logic       oob_incompatible_i,
    input  logic       link_up_i,
    input  logic       link_down_i,
    input  logic       cominit_req_i,
    output logic       cominit_allow_o,
    input  logic       txpcsreset_req_i,
    output logic       txpcsreset_o,
    input  logic       txresetdone_i,
    output logic       recal_tx_done_o,
    output logic       phy_ready_o,
    output logic [3:0] retry_cnt_o,
    output logic       gave_up_o
);

    // Main FSM encoding
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_OOB  = 3'd2;
    localparam logic [2:0] S_WAIT_LINK = 3'd3;
    localparam logic [2:0] S_LINK      = 3'd4;
    localparam logic [2:0] S_BACKOFF   = 3'd5;
    localparam logic [2:0] S_FAIL      = 3'd6;

    // PCS recalibration FSM encoding
    localparam logic [1:0] PR_IDLE  = 2'd0;
    localparam logic [1:0] PR_PULSE = 2'd1;
    localparam logic [1:0] PR_WAIT  = 2'd2;
    localparam logic [1:0] PR_HOLD  = 2'd3;

    // One timer serves both the back-off and the 256-cycle link-up window
    localparam int TMR_MAX = (RETRY_WAIT > 256) ? RETRY_WAIT : 256;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] BACKOFF_LAST = TMR_W'(RETRY_WAIT - 1);
    localparam logic [TMR_W-1:0] LINKUP_LAST  = TMR_W'(255);

    localparam int LD_W = $clog2(LINKDOWN_FILT + 1);
    localparam logic [LD_W-1:0] LD_LAST = LD_W'(LINKDOWN_FILT - 1);

    localparam int PCS_MAX = (PCS_RST_CYCLES > PCS_RST_TMO) ? PCS_RST_CYCLES : PCS_RST_TMO;
    localparam int PCNT_W  = $clog2(PCS_MAX + 1);
    localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PCS_RST_CYCLES - 1);
    localparam logic [PCNT_W-1:0] TMO_LAST   = PCNT_W'(PCS_RST_TMO - 1);

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

    logic [2:0]        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [3:0]        retry_q, retry_d;
    logic [LD_W-1:0]   ld_q, ld_d;
    logic              start_q, start_d;
    logic              allow_q, allow_d;
    logic              phy_q, phy_d;
    logic              gave_q, gave_d;

    logic [1:0]        pr_q, pr_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              req_q;
    logic              abort_q, abort_d;
    logic              pcsrst_q, pcsrst_d;
    logic              recal_q, recal_d;

    logic              oob_fail;
    logic [3:0]        retry_inc;

    assign oob_fail  = oob_error_i | oob_silence_i | oob_incompatible_i;
    assign retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

    // Main FSM state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            retry_q <= '0;
            ld_q    <= '0;
            start_q <= 1'b0;
            allow_q <= 1'b0;
            phy_q   <= 1'b0;
            gave_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            retry_q <= retry_d;
            ld_q    <= ld_d;
            start_q <= start_d;
            allow_q <= allow_d;
            phy_q   <= phy_d;
            gave_q  <= gave_d;
        end
    end

    // Main FSM next state and retry accounting
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            S_IDLE: begin
                if (enable_i) state_d = cominit_req_i ? S_WAIT_OOB : S_START;
            end
            S_START: begin
                if (!enable_i)        state_d = S_IDLE;
                else if (!oob_busy_i) state_d = S_WAIT_OOB;
            end
            S_WAIT_OOB: begin
                // A failure indication wins over a simultaneous oob_done
                if (oob_fail) begin
                    retry_d = retry_inc;
                    state_d = enable_i ? S_BACKOFF : S_IDLE;
                end else if (oob_done_i) begin
                    state_d = enable_i ? S_WAIT_LINK : S_IDLE;
                end
            end
            S_WAIT_LINK: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (link_up_i) begin
                    state_d = S_LINK;
                    retry_d = '0;
                end else if (tmr_q == LINKUP_LAST) begin
                    state_d = S_BACKOFF;
                    retry_d = retry_inc;
                end
            end
            S_LINK: begin
                if (!enable_i)                            state_d = S_IDLE;
                else if (cominit_req_i)                   state_d = S_WAIT_OOB;
                else if (link_down_i && (ld_q == LD_LAST)) state_d = S_BACKOFF;
            end
            S_BACKOFF: begin
                if (!enable_i)              state_d = S_IDLE;
                else if (cominit_req_i)     state_d = S_WAIT_OOB;
                else if (tmr_q == BACKOFF_LAST)
                    state_d = (retry_q == RETRY_LIMIT) ? S_FAIL : S_START;
            end
            S_FAIL: begin
                if (!enable_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) retry_d = '0;
    end

    // Main FSM outputs: WAIT_OOB entered from START is our own attempt, any other entry is a COMINIT grant
    always_comb begin
        start_d = (state_q == S_START) && (state_d == S_WAIT_OOB);
        allow_d = (state_d == S_WAIT_OOB) && (state_q != S_START) && (state_q != S_WAIT_OOB);
        phy_d   = (state_d == S_LINK);
        gave_d  = (state_d == S_FAIL);
        tmr_d   = (state_d != state_q) ? '0 : tmr_q + 1'b1;
        ld_d    = ((state_q == S_LINK) && link_down_i) ? ld_q + 1'b1 : '0;
    end

    // PCS FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_q     <= PR_IDLE;
            pcnt_q   <= '0;
            req_q    <= 1'b0;
            abort_q  <= 1'b0;
            pcsrst_q <= 1'b0;
            recal_q  <= 1'b0;
        end else begin
            pr_q     <= pr_d;
            pcnt_q   <= pcnt_d;
            req_q    <= txpcsreset_req_i;
            abort_q  <= abort_d;
            pcsrst_q <= pcsrst_d;
            recal_q  <= recal_d;
        end
    end

    // PCS FSM next state; a request dropped mid-pulse still completes the pulse
    always_comb begin
        pr_d    = pr_q;
        abort_d = abort_q;
        case (pr_q)
            PR_IDLE: begin
                abort_d = 1'b0;
                if (txpcsreset_req_i && !req_q) pr_d = PR_PULSE;
            end
            PR_PULSE: begin
                if (!txpcsreset_req_i) abort_d = 1'b1;
                if (pcnt_q == PULSE_LAST)
                    pr_d = (abort_q || !txpcsreset_req_i) ? PR_IDLE : PR_WAIT;
            end
            PR_WAIT: begin
                if (!txpcsreset_req_i)                    pr_d = PR_IDLE;
                else if (txresetdone_i || pcnt_q == TMO_LAST) pr_d = PR_HOLD;
            end
            PR_HOLD: begin
                if (!txpcsreset_req_i) pr_d = PR_IDLE;
            end
            default: pr_d = PR_IDLE;
        endcase
    end

    // PCS FSM outputs and cycle counter
    always_comb begin
        pcnt_d   = (pr_d != pr_q) ? '0 : pcnt_q + 1'b1;
        pcsrst_d = (pr_d == PR_PULSE);
        recal_d  = (pr_q == PR_WAIT) && txpcsreset_req_i && txresetdone_i;
    end

    assign oob_start_o     = start_q;
    assign cominit_allow_o = allow_q;
    assign phy_ready_o     = phy_q;
    assign gave_up_o       = gave_q;
    assign retry_cnt_o     = retry_q;
    assign txpcsreset_o    = pcsrst_q;
    assign recal_tx_done_o = recal_q;

endmodule
`default_nettype wire

// File: tb/tb_oob_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oob_ctrl
//  Purpose  : Self-checking bench for oob_ctrl: vector table for single-cycle
//             transitions plus hand sequences for retries, link loss filter,
//             PCS recalibration and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_oob_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, oob_busy, oob_done, oob_error, oob_silence, oob_incompatible;
    logic       link_up, link_down, cominit_req, txpcsreset_req, txresetdone;
    logic       oob_start, cominit_allow, txpcsreset, recal_tx_done, phy_ready, gave_up;
    logic [3:0] retry_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_start, n_allow, n_pcs, n_recal, last_start, min_gap;

    always #5 clk = ~clk;

    oob_ctrl #(
        .RETRY_WAIT     (100),
        .MAX_RETRIES    (4),
        .PCS_RST_CYCLES (8),
        .PCS_RST_TMO    (4096),
        .LINKDOWN_FILT  (16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .enable_i           (enable),
        .oob_start_o        (oob_start),
        .oob_busy_i         (oob_busy),
        .oob_done_i         (oob_done),
        .oob_error_i        (oob_error),
        .oob_silence_i      (oob_silence),
        .oob_incompatible_i (oob_incompatible),
        .link_up_i          (link_up),
        .link_down_i        (link_down),
        .cominit_req_i      (cominit_req),
        .cominit_allow_o    (cominit_allow),
        .txpcsreset_req_i   (txpcsreset_req),
        .txpcsreset_o       (txpcsreset),
        .txresetdone_i      (txresetdone),
        .recal_tx_done_o    (recal_tx_done),
        .phy_ready_o        (phy_ready),
        .retry_cnt_o        (retry_cnt),
        .gave_up_o          (gave_up)
    );

    // in : {en, busy, done, err, sil, incompat, cominit, link_up, link_down}
    // exp: {oob_start, cominit_allow, phy_ready, gave_up, retry_cnt[3:0]}
    typedef struct packed {
        logic [8:0] in;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [7:0] main_outs();
        return {oob_start, cominit_allow, phy_ready, gave_up, retry_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_counts();
        n_start = 0; n_allow = 0; n_pcs = 0; n_recal = 0;
        last_start = -1; min_gap = 1000000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (oob_start) begin
            if (last_start >= 0 && (cyc - last_start) < min_gap) min_gap = cyc - last_start;
            last_start = cyc;
            n_start++;
        end
        if (cominit_allow) n_allow++;
        if (txpcsreset)    n_pcs++;
        if (recal_tx_done) n_recal++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_inputs();
        enable = 0; oob_busy = 0; oob_done = 0; oob_error = 0; oob_silence = 0;
        oob_incompatible = 0; link_up = 0; link_down = 0; cominit_req = 0;
        txpcsreset_req = 0; txresetdone = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        ticks(3);
        rst_n = 1;
        tick();
        clear_counts();
    endtask

    task automatic wait_start(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (oob_start) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic pulse_done();    oob_done = 1;    tick(); oob_done = 0;    endtask
    task automatic pulse_error();   oob_error = 1;   tick(); oob_error = 0;   endtask
    task automatic pulse_silence(); oob_silence = 1; tick(); oob_silence = 0; endtask
    task automatic pulse_linkup();  link_up = 1;     tick(); link_up = 0;     endtask

    // enable, OOB unit answers oob_done 50 cycles after oob_start and link_up one cycle later
    task automatic bring_up(input string name);
        bit ok;
        enable = 1;
        wait_start(20, ok);
        check({name, "_start_seen"}, ok, 1);
        ticks(49);
        pulse_done();
        pulse_linkup();
    endtask

    initial begin
        bit ok;
        clear_inputs();
        clear_counts();
        rst_n = 0;
        ticks(2);
        check("reset_state", {txpcsreset, recal_tx_done, main_outs()}, 10'h000);
        rst_n = 1;
        tick();

        // ---- table-driven single-cycle transitions ----
        tbl[0]  = '{9'b0_0000_0000, 8'b0000_0000};  // idle, enable low
        tbl[1]  = '{9'b1_1000_0000, 8'b0000_0000};  // idle -> start
        tbl[2]  = '{9'b1_1000_0000, 8'b0000_0000};  // busy holds start
        tbl[3]  = '{9'b1_0000_0000, 8'b1000_0000};  // oob_start pulse
        tbl[4]  = '{9'b1_0000_0100, 8'b0000_0000};  // cominit ignored in WAIT_OOB
        tbl[5]  = '{9'b1_0110_0000, 8'b0000_0001};  // error beats done
        tbl[6]  = '{9'b1_0000_0100, 8'b0100_0001};  // cominit granted in BACKOFF
        tbl[7]  = '{9'b1_0100_0000, 8'b0000_0001};  // done -> WAIT_LINK
        tbl[8]  = '{9'b1_0000_0010, 8'b0010_0000};  // link_up -> LINK, cnt 0
        tbl[9]  = '{9'b1_0000_0001, 8'b0010_0000};  // single link_down cycle filtered
        tbl[10] = '{9'b1_0000_0100, 8'b0100_0000};  // cominit in LINK
        tbl[11] = '{9'b0_0100_0000, 8'b0000_0000};  // enable low honoured on done
        tbl[12] = '{9'b1_0000_0100, 8'b0100_0000};  // cominit granted in IDLE
        tbl[13] = '{9'b0_0000_1000, 8'b0000_0000};  // incompatible with enable low -> IDLE
        tbl[14] = '{9'b1_0000_0000, 8'b0000_0000};  // idle -> start
        tbl[15] = '{9'b0_0000_0000, 8'b0000_0000};  // enable low in START -> IDLE
        for (int i = 0; i < 16; i++) begin
            {enable, oob_busy, oob_done, oob_error, oob_silence, oob_incompatible,
             cominit_req, link_up, link_down} = tbl[i].in;
            tick();
            check($sformatf("vec%0d", i), main_outs(), tbl[i].exp);
        end
        clear_inputs();
        tick();

        // ---- WAIT_LINK 256-cycle window ----
        enable = 1;
        wait_start(20, ok);
        ticks(3);
        pulse_done();
        ticks(255);
        check("linkwin_255", retry_cnt, 0);
        tick();
        check("linkwin_256", retry_cnt, 1);

        // ---- 1: clean bring-up ----
        do_reset();
        bring_up("t1");
        check("t1_starts", n_start, 1);
        check("t1_phy_ready", phy_ready, 1);
        check("t1_retry", retry_cnt, 0);

        // ---- 2: three silences then success ----
        do_reset();
        enable = 1;
        for (int k = 0; k < 3; k++) begin
            wait_start(300, ok);
            check($sformatf("t2_start%0d", k), ok, 1);
            ticks(5);
            pulse_silence();
            check($sformatf("t2_retry%0d", k), retry_cnt, k + 1);
        end
        wait_start(300, ok);
        ticks(49);
        pulse_done();
        pulse_linkup();
        check("t2_retry_clr", retry_cnt, 0);
        check("t2_phy_ready", phy_ready, 1);
        check("t2_gap_ok", min_gap >= 101, 1);

        // ---- 3: persistent error until FAIL ----
        do_reset();
        enable = 1;
        for (int k = 0; k < 6; k++) begin
            wait_start(300, ok);
            if (!ok) break;
            tick();
            pulse_error();
        end
        check("t3_starts", n_start, 4);
        check("t3_gave_up", gave_up, 1);
        check("t3_retry", retry_cnt, 4);
        enable = 0;
        ticks(2);
        check("t3_idle", main_outs(), 8'h00);

        // ---- 4: link_down filter ----
        do_reset();
        bring_up("t4");
        link_down = 1;
        ticks(15);
        link_down = 0;
        tick();
        check("t4_burst15", phy_ready, 1);
        link_down = 1;
        ticks(15);
        check("t4_burst2_15", phy_ready, 1);
        tick();
        check("t4_burst2_16", phy_ready, 0);
        check("t4_no_retry", retry_cnt, 0);
        link_down = 0;

        // ---- 5: PCS recalibration ----
        do_reset();
        txpcsreset_req = 1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 27) txresetdone = 1;
        end
        check("t5_pulse_len", n_pcs, 8);
        check("t5_recal_once", n_recal, 1);
        txpcsreset_req = 0;
        txresetdone = 0;
        ticks(3);
        clear_counts();
        txpcsreset_req = 1;
        ticks(4200);
        check("t5_tmo_pulse", n_pcs, 8);
        check("t5_tmo_norecal", n_recal, 0);
        txresetdone = 1;
        ticks(5);
        check("t5_hold_norecal", n_recal, 0);
        txpcsreset_req = 0;
        txresetdone = 0;
        ticks(3);
        clear_counts();
        txpcsreset_req = 1;
        ticks(3);
        txpcsreset_req = 0;
        txresetdone = 1;
        ticks(20);
        check("t5_abort_pulse", n_pcs, 8);
        check("t5_abort_norecal", n_recal, 0);
        txresetdone = 0;

        // ---- 6: cominit during BACKOFF, async reset ----
        do_reset();
        enable = 1;
        wait_start(20, ok);
        tick();
        pulse_silence();
        check("t6_retry", retry_cnt, 1);
        cominit_req = 1;
        tick();
        check("t6_grant", {oob_start, cominit_allow}, 2'b01);
        cominit_req = 0;
        ticks(150);
        check("t6_no_start", n_start, 1);
        check("t6_one_grant", n_allow, 1);
        txpcsreset_req = 1;
        tick();
        #2 rst_n = 0;
        #1;
        check("t6_async_reset", {txpcsreset, recal_tx_done, main_outs()}, 10'h000);
        clear_inputs();
        tick();
        rst_n = 1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
